// File: rtl/smi_mem_target_burst64.sv
// smi_mem_target_burst64: SMI memory responder backed by an internal 64-bit word array
module smi_mem_target_burst64 #(
  parameter logic [63:0] MemAddrBase   = 64'h0,
  parameter int          MemAddrWidth  = 10,
  parameter int          MaxBurstWords = 256
) (
  input  logic        clk,
  input  logic        srst,
  input  logic        smiReqValid,
  input  logic [7:0]  smiReqEofc,
  input  logic [63:0] smiReqData,
  output logic        smiReqStop,
  output logic        smiRespValid,
  output logic [7:0]  smiRespEofc,
  output logic [63:0] smiRespData,
  input  logic        smiRespStop
);
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WRDATA, S_DRAIN, S_RESP, S_RDHDR, S_RDDATA} state_t;
  localparam logic [64:0] TOP  = {1'b0, MemAddrBase} + (65'd1 << (MemAddrWidth + 3));
  localparam logic [15:0] MAXB = 16'(MaxBurstWords);
  state_t r_state, w_next;
  logic r_req_stop, r_resp_valid, r_ok, r_wen, r_mq_v, r_pf_v;
  logic [7:0] r_resp_eofc, r_op, r_tag;
  logic [63:0] r_resp_data, r_mq, r_pf;
  logic [15:0] r_len, r_cnt, r_rd_left, r_out_left;
  logic [MemAddrWidth-1:0] r_idx, w_idx;
  logic [63:0] r_mem [2**MemAddrWidth];
  logic w_acc, w_fire, w_out_ready, w_out_load, w_mq_take, w_issue, w_hdr_load, w_wr, w_chk;
  logic [64:0] w_end;
  logic [63:0] w_rsp;
  assign smiReqStop   = r_req_stop;
  assign smiRespValid = r_resp_valid;
  assign smiRespEofc  = r_resp_eofc;
  assign smiRespData  = r_resp_data;
  assign w_acc       = smiReqValid && !r_req_stop;
  assign w_fire      = r_resp_valid && !smiRespStop;
  assign w_out_ready = !r_resp_valid || !smiRespStop;
  assign w_out_load  = r_state == S_RDDATA && w_out_ready && (r_pf_v || r_mq_v) && r_out_left != 16'd0;
  assign w_mq_take   = r_mq_v && (!r_pf_v || w_out_load);
  assign w_issue     = (r_state == S_RDHDR || r_state == S_RDDATA) && r_rd_left != 16'd0 && (!r_mq_v || w_mq_take);
  assign w_hdr_load  = (r_state == S_RESP || r_state == S_RDHDR) && !r_resp_valid;
  assign w_wr        = r_state == S_WRDATA && w_acc && r_wen;
  assign w_rsp       = {47'd0, r_ok, r_tag, r_op | 8'h80};
  assign w_idx       = MemAddrWidth'((smiReqData - MemAddrBase) >> 3);
  assign w_end       = {1'b0, smiReqData} + {46'd0, r_len, 3'd0};
  assign w_chk       = (r_op == 8'h01 || r_op == 8'h02) && r_len != 16'd0 && r_len <= MAXB &&
                       smiReqData[2:0] == 3'd0 && smiReqData >= MemAddrBase && w_end <= TOP;
  // state register
  always_ff @(posedge clk or negedge srst)
    if (!srst) r_state <= S_IDLE;
    else r_state <= w_next;
  // next-state: frame parsing, then response/read emission with requests held off
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_acc) w_next = smiReqEofc != 8'd0 ? S_RESP : S_ADDR;
      S_ADDR:   if (w_acc) w_next = smiReqEofc != 8'd0 ? ((r_op == 8'h02 && w_chk) ? S_RDHDR : S_RESP)
                                                       : (r_op == 8'h02 ? S_DRAIN : S_WRDATA);
      S_WRDATA: if (w_acc) w_next = smiReqEofc != 8'd0 ? S_RESP : (r_cnt >= r_len ? S_DRAIN : S_WRDATA);
      S_DRAIN:  if (w_acc && smiReqEofc != 8'd0) w_next = S_RESP;
      S_RESP:   if (w_fire) w_next = S_IDLE;
      S_RDHDR:  if (w_fire) w_next = S_RDDATA;
      S_RDDATA: if (w_fire && r_resp_eofc != 8'd0) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end
  // frame context, read prefetch pipeline and response output register
  always_ff @(posedge clk or negedge srst)
    if (!srst) begin
      r_req_stop   <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_eofc  <= 8'd0;
      r_resp_data  <= 64'd0;
      r_op         <= 8'd0;
      r_tag        <= 8'd0;
      r_len        <= 16'd0;
      r_cnt        <= 16'd0;
      r_rd_left    <= 16'd0;
      r_out_left   <= 16'd0;
      r_ok         <= 1'b0;
      r_wen        <= 1'b0;
      r_idx        <= '0;
      r_mq_v       <= 1'b0;
      r_pf_v       <= 1'b0;
      r_pf         <= 64'd0;
    end else begin
      r_req_stop <= w_next inside {S_RESP, S_RDHDR, S_RDDATA};
      if (r_state == S_IDLE && w_acc) begin
        r_op  <= smiReqData[7:0];
        r_tag <= smiReqData[15:8];
        r_len <= smiReqData[31:16];
        r_ok  <= 1'b0;
      end
      if (r_state == S_ADDR && w_acc) begin
        r_idx      <= w_idx;
        r_cnt      <= 16'd1;
        r_rd_left  <= r_len;
        r_out_left <= r_len;
        r_wen      <= w_chk && smiReqEofc == 8'd0;
        r_ok       <= w_chk && ((smiReqEofc != 8'd0) == (r_op == 8'h02));
      end
      if (r_state == S_WRDATA && w_acc) begin
        r_cnt <= r_cnt + 16'd1;
        if (smiReqEofc != 8'd0) r_ok <= r_ok && r_cnt == r_len && smiReqEofc == 8'd8;
        else if (r_cnt >= r_len) r_ok <= 1'b0;
      end
      if (w_wr || w_issue) r_idx <= r_idx + 1'b1;
      if (w_issue) r_rd_left <= r_rd_left - 16'd1;
      if (w_issue) r_mq_v <= 1'b1;
      else if (w_mq_take) r_mq_v <= 1'b0;
      if (w_out_load && r_pf_v) begin
        r_pf_v <= r_mq_v;
        r_pf   <= r_mq;
      end else if (!w_out_load && w_mq_take) begin
        r_pf_v <= 1'b1;
        r_pf   <= r_mq;
      end
      if (w_fire) r_resp_valid <= 1'b0;
      if (w_hdr_load) begin
        r_resp_valid <= 1'b1;
        r_resp_data  <= w_rsp;
        r_resp_eofc  <= r_state == S_RESP ? 8'd8 : 8'd0;
      end
      if (w_out_load) begin
        r_resp_valid <= 1'b1;
        r_resp_data  <= r_pf_v ? r_pf : r_mq;
        r_resp_eofc  <= r_out_left == 16'd1 ? 8'd8 : 8'd0;
        r_out_left   <= r_out_left - 16'd1;
      end
    end
  // single-port array: write during WrData, otherwise registered read for the prefetch pipe
  always_ff @(posedge clk)
    if (w_wr) r_mem[r_idx] <= smiReqData;
    else if (w_issue) r_mq <= r_mem[r_idx];
endmodule

// File: tb/tb_smi_mem_target_burst64.sv
// tb_smi_mem_target_burst64: table-driven and sequence checks for the SMI memory target
module tb_smi_mem_target_burst64;
  localparam logic [63:0] B   = 64'h10000;
  localparam logic [63:0] TOP = B + 64'h2000;
  localparam logic [63:0] P   = 64'hABCD_0000_0000_0001;
  localparam logic [63:0] Z   = 64'h5A5A_0000_0000_0010;
  localparam logic [63:0] DD  = 64'h0000_0000_7777_0001;
  localparam logic [63:0] LS  = 64'h0101_0000_0000_0003;
  localparam logic [63:0] A1  = 64'h1111_1111_1111_1111;
  typedef struct {
    logic [7:0]  op;
    logic [7:0]  tag;
    logic [15:0] len;
    logic [63:0] addr;
    logic [7:0]  hdr_e;
    logic [7:0]  adr_e;
    int          nd;
    logic [7:0]  last_e;
    logic [63:0] exp_d;
  } vec_t;
  logic clk = 1'b0, srst = 1'b0;
  logic smiReqValid = 1'b0, smiReqStop, smiRespValid, smiRespStop = 1'b0;
  logic [7:0] smiReqEofc = 8'd0, smiRespEofc;
  logic [63:0] smiReqData = 64'd0, smiRespData;
  int checks = 0, failures = 0, ph = 0;
  logic [63:0] xq[$];
  vec_t vt[13];
  always #5 clk = ~clk;
  smi_mem_target_burst64 #(.MemAddrBase(B), .MemAddrWidth(10), .MaxBurstWords(256)) dut (
    .clk(clk), .srst(srst),
    .smiReqValid(smiReqValid), .smiReqEofc(smiReqEofc), .smiReqData(smiReqData), .smiReqStop(smiReqStop),
    .smiRespValid(smiRespValid), .smiRespEofc(smiRespEofc), .smiRespData(smiRespData), .smiRespStop(smiRespStop)
  );
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] x);
    checks++;
    if (a !== x) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, a, x);
    end
  endtask
  task automatic tmo(input string nm);
    checks++;
    failures++;
    $display("FAIL %s timeout got=none exp=handshake", nm);
  endtask
  task automatic send(input logic [63:0] d, input logic [7:0] e);
    int n = 0;
    smiReqValid = 1'b1;
    smiReqData = d;
    smiReqEofc = e;
    while (smiReqStop && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (smiReqStop) tmo("send");
    else begin
      @(posedge clk); #1;
    end
    smiReqValid = 1'b0;
    smiReqEofc = 8'd0;
  endtask
  task automatic hdr(input logic [7:0] op, input logic [7:0] tag, input logic [15:0] len, input logic [7:0] e);
    send({32'hDEAD_BEEF, len, tag, op}, e);
  endtask
  task automatic recv(output logic [63:0] d, output logic [7:0] e, input bit tog, output bit ok);
    ok = 1'b0;
    d = 64'd0;
    e = 8'd0;
    for (int n = 0; n < 100 && !ok; n++) begin
      smiRespStop = tog ? ph[1] : 1'b0;
      ph++;
      if (smiRespValid && !smiRespStop) begin
        d = smiRespData;
        e = smiRespEofc;
        ok = 1'b1;
      end
      @(posedge clk); #1;
    end
    smiRespStop = 1'b0;
    if (!ok) tmo("recv");
  endtask
  task automatic rsp(input string nm, input logic [63:0] xd, input logic [7:0] xe, input bit tog);
    logic [63:0] d;
    logic [7:0] e;
    bit ok;
    recv(d, e, tog, ok);
    if (ok) begin
      chk({nm, "_data"}, d, xd);
      chk({nm, "_eofc"}, 64'(e), 64'(xe));
    end
  endtask
  task automatic wr(input logic [7:0] tag, input logic [63:0] addr, input logic [15:0] len, input int n, input logic [63:0] seed);
    hdr(8'h01, tag, len, 8'd0);
    send(addr, 8'd0);
    for (int j = 0; j < n; j++) send(seed * 64'(j + 1), j == n - 1 ? 8'd8 : 8'd0);
  endtask
  task automatic rd(input logic [7:0] tag, input logic [63:0] addr, input logic [15:0] len);
    hdr(8'h02, tag, len, 8'd0);
    send(addr, 8'd8);
  endtask
  task automatic rdchk(input string nm, input logic [7:0] tag, input logic [63:0] addr, input bit tog);
    logic [63:0] d;
    logic [7:0] e;
    bit ok;
    rd(tag, addr, 16'(xq.size()));
    rsp({nm, "_hdr"}, {47'd0, 1'b1, tag, 8'h82}, 8'd0, tog);
    for (int i = 0; i < xq.size(); i++) begin
      recv(d, e, tog, ok);
      if (!ok) break;
      chk($sformatf("%s_d%0d", nm, i), d, xq[i]);
      chk($sformatf("%s_e%0d", nm, i), 64'(e), i == xq.size() - 1 ? 64'd8 : 64'd0);
    end
  endtask
  initial begin
    logic [63:0] d;
    logic [7:0] e;
    bit ok;
    vt[0]  = '{8'h01, 8'h10, 16'd2,   B + 64'h4,   8'd0, 8'd0, 2, 8'd8, 64'h1081};
    vt[1]  = '{8'h01, 8'h11, 16'd3,   B + 64'h300, 8'd0, 8'd0, 2, 8'd8, 64'h1181};
    vt[2]  = '{8'h05, 8'h12, 16'd1,   B + 64'h300, 8'd0, 8'd0, 1, 8'd8, 64'h1285};
    vt[3]  = '{8'h02, 8'h13, 16'd0,   B,           8'd0, 8'd8, 0, 8'd0, 64'h1382};
    vt[4]  = '{8'h02, 8'h14, 16'd257, B,           8'd0, 8'd8, 0, 8'd0, 64'h1482};
    vt[5]  = '{8'h02, 8'h15, 16'd2,   TOP - 64'h8, 8'd0, 8'd8, 0, 8'd0, 64'h1582};
    vt[6]  = '{8'h02, 8'h16, 16'd1,   B - 64'h8,   8'd0, 8'd8, 0, 8'd0, 64'h1682};
    vt[7]  = '{8'h01, 8'h17, 16'd1,   B,           8'd8, 8'd0, 0, 8'd0, 64'h1781};
    vt[8]  = '{8'h01, 8'h18, 16'd1,   B + 64'h300, 8'd0, 8'd8, 0, 8'd0, 64'h1881};
    vt[9]  = '{8'h01, 8'h19, 16'd1,   TOP - 64'h8, 8'd0, 8'd0, 1, 8'd8, 64'h11981};
    vt[10] = '{8'h01, 8'h1A, 16'd2,   B + 64'h300, 8'd0, 8'd0, 2, 8'd4, 64'h1A81};
    vt[11] = '{8'h02, 8'h1B, 16'd1,   B,           8'd0, 8'd0, 1, 8'd8, 64'h1B82};
    vt[12] = '{8'h00, 8'h1D, 16'd1,   B,           8'd0, 8'd8, 0, 8'd0, 64'h1D80};
    repeat (3) @(negedge clk);
    chk("rst_req_stop", 64'(smiReqStop), 64'd1);
    chk("rst_resp_valid", 64'(smiRespValid), 64'd0);
    chk("rst_resp_eofc", 64'(smiRespEofc), 64'd0);
    chk("rst_resp_data", smiRespData, 64'd0);
    srst = 1'b1;
    @(posedge clk); #1;
    chk("rel_req_stop", 64'(smiReqStop), 64'd0);
    wr(8'h21, B + 64'h40, 16'd4, 4, A1);
    rsp("wr_a", 64'h1_2181, 8'd8, 1'b0);
    xq = {A1, A1 * 2, A1 * 3, A1 * 4};
    rdchk("rd_a", 8'h22, B + 64'h40, 1'b0);
    wr(8'h23, B, 16'd2, 2, P);
    rsp("wr_p", 64'h1_2381, 8'd8, 1'b0);
    wr(8'h24, B + 64'h4, 16'd2, 2, 64'hBAD0_0000_0000_0001);
    rsp("wr_mis", 64'h2481, 8'd8, 1'b0);
    xq = {P, P * 2};
    rdchk("rd_mis", 8'h25, B, 1'b0);
    for (int i = 0; i < 13; i++) begin
      hdr(vt[i].op, vt[i].tag, vt[i].len, vt[i].hdr_e);
      if (vt[i].hdr_e == 8'd0) begin
        send(vt[i].addr, vt[i].adr_e);
        if (vt[i].adr_e == 8'd0)
          for (int j = 0; j < vt[i].nd; j++)
            send(64'hF00D_0000_0000_0000 + 64'(j), j == vt[i].nd - 1 ? vt[i].last_e : 8'd0);
      end
      rsp($sformatf("vec%0d", i), vt[i].exp_d, 8'd8, 1'b0);
    end
    wr(8'h26, B + 64'h100, 16'd3, 3, Z);
    rsp("wr_z", 64'h1_2681, 8'd8, 1'b0);
    wr(8'h27, B + 64'h100, 16'd2, 5, DD);
    rsp("wr_long", 64'h2781, 8'd8, 1'b0);
    xq = {DD, DD * 2, Z * 3};
    rdchk("rd_drain", 8'h28, B + 64'h100, 1'b0);
    wr(8'h29, TOP - 64'd2048, 16'd256, 256, LS);
    rsp("wr_max", 64'h1_2981, 8'd8, 1'b0);
    xq = {};
    for (int i = 0; i < 256; i++) xq.push_back(LS * 64'(i + 1));
    rdchk("rd_max", 8'h2A, TOP - 64'd2048, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    chk("rd_max_tail_valid", 64'(smiRespValid), 64'd0);
    rd(8'h2B, TOP - 64'd2048, 16'd256);
    rsp("rst_rd_hdr", 64'h1_2B82, 8'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      recv(d, e, 1'b0, ok);
      if (ok) chk($sformatf("rst_rd_d%0d", i), d, LS * 64'(i + 1));
    end
    chk("mid_valid", 64'(smiRespValid), 64'd1);
    @(negedge clk);
    srst = 1'b0;
    #1;
    chk("async_resp_valid", 64'(smiRespValid), 64'd0);
    chk("async_req_stop", 64'(smiReqStop), 64'd1);
    chk("async_resp_data", smiRespData, 64'd0);
    repeat (2) @(negedge clk);
    srst = 1'b1;
    @(posedge clk); #1;
    chk("rel2_req_stop", 64'(smiReqStop), 64'd0);
    xq = {A1, A1 * 2, A1 * 3, A1 * 4};
    rdchk("rd_after_rst", 8'h2C, B + 64'h40, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/smi_mem_target_burst64.md
Name: smi_mem_target_burst64

Overview:
- SMI memory target (responder) for 64-bit burst traffic. It terminates the request/response channel pair that burst initiators and fuzz testers drive.
- Backed by an internal single-port word array that covers a configurable byte-address window. Write frames store data and return a status frame. Read frames return the stored data.
- Used as the memory endpoint in self-test and simulation builds in place of the external memory controller.

Parameters:
- MemAddrBase, 64'h0, byte address of word 0 of the window; must be 8-byte aligned.
- MemAddrWidth, 10, log2 of the number of 64-bit words; the window is 2^MemAddrWidth*8 bytes.
- MaxBurstWords, 256, largest accepted burst length in words (1..65535).

Ports:
- clk  in  1  system clock.
- srst  in  1  asynchronous, active-low reset.
- smiReqValid  in  1  request flit valid.
- smiReqEofc  in  8  request end-of-frame control; 0 = mid frame, 1..8 = last flit with that many valid bytes.
- smiReqData  in  64  request flit data.
- smiReqStop  out  1  request backpressure.
- smiRespValid  out  1  response flit valid.
- smiRespEofc  out  8  response end-of-frame control.
- smiRespData  out  64  response flit data.
- smiRespStop  in  1  response backpressure.

Behaviour:
- Handshake: a flit transfers on a rising clk edge when valid=1 and stop=0. Once asserted, smiRespValid, smiRespData and smiRespEofc hold until the flit transfers.
- Reset (srst=0, async): state=Idle, smiReqStop=1, smiRespValid=0, smiRespEofc=0, smiRespData=0. The array contents are not reset.
- First cycle after reset release: smiReqStop falls to 0.
- Request flit 0 (header):
  - [7:0] opcode: 8'h01 write, 8'h02 read.
  - [15:8] tag.
  - [31:16] length in words.
  - [63:32] ignored.
- Request flit 1: 64-bit byte address.
- Write frames carry flits 2..length+1 as data. The data words are little-endian and the last flit has eofc=8.
- Read frames end at flit 1 with eofc=8.
- A request is valid only if all of the following hold:
  - opcode is 01 or 02;
  - 1 <= length <= MaxBurstWords;
  - addr[2:0]=0;
  - MemAddrBase <= addr;
  - addr + length*8 <= MemAddrBase + 2^MemAddrWidth*8. This sum is computed at 65 bits, so there is no wrap.
- Word index = (addr-MemAddrBase)>>3 and increments by 1 per data word.
- States:
  - Idle: accept the header; latch opcode, tag and length. Header eofc!=0 -> Resp with error.
  - Addr: accept the address and run the checks. If eofc!=0: read -> ReadHdr (or Resp with error if the checks fail); write -> Resp with error. If eofc=0: a read goes to Drain; a write goes to WrData, with writes enabled only if the checks passed.
  - WrData: one array write per accepted flit when enabled. Eofc on the flit with count==length -> Resp. The status is OK only if eofc==8 and the checks passed.
    - Early eofc -> Resp with error.
    - No eofc at the length-th flit -> Drain.
  - Drain: discard flits up to and including the eofc flit, then go to Resp with error.
  - Resp: emit one flit {47'd0, status, tag, opcode|8'h80} with eofc=8, then return to Idle.
  - ReadHdr: emit the header flit (status=1), then go to RdData.
  - RdData: emit length data words; the last word has eofc=8, then return to Idle.
- smiReqStop=1 in Resp, ReadHdr and RdData, so only one request is outstanding.
- Read latency: the array read is registered. The first data flit is presented no earlier than the cycle after the header flit transfers. Under continuous ready, RdData runs at one flit per cycle; a one-word prefetch register absorbs smiRespStop.
- Read-after-write to the same address returns the new data, because frames are serialized.
- Opcode 01/02 with illegal length or address: the header is returned with status=0 and no data follows. An unknown opcode is echoed with bit 7 set and status=0.

Test Plan:
- Write len=4 at MemAddrBase+0x40, data 0x1111..0x4444, then read the same location. Expect a write response {status=1, tag} with eofc=8. Expect a read header with status=1, then 4 words matching, the last with eofc=8.
- Read len=MaxBurstWords ending exactly at the top of the window with smiRespStop toggling every 2 cycles. Expect all words in order, none dropped or duplicated, and the last word with eofc=8.
- Write at addr=MemAddrBase+0x4 (misaligned) with len=2. Expect no array change (verified by a following read) and a response with status=0.
- Write header len=3 but frame ends after 2 data flits. Expect an error response immediately after the eofc flit.
- Write header len=2 with 5 data flits. Expect 2 words stored, the remaining flits drained, and status=0.
- Assert srst mid-RdData. Expect smiRespValid=0 and smiReqStop=1 asynchronously. After release, a fresh read returns the previously written data.
